// File: rtl/clk_div.sv
// Synchronous integer clock divider: a registered, glitch-free divided clock
// that stays low for ceil(DIV/2) input cycles and high for floor(DIV/2).
module clk_div #(
    parameter int DIV = 5
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LOW   = DIV - DIV / 2;

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LOW_C = CNT_W'(LOW);

    generate
        if (DIV < 2 || DIV > 65535) begin : g_div_check
            $error("clk_div: DIV must lie in 2..65535");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Codes above LAST are unreachable, but any that appear fold back to 0.
    always_comb begin
        cnt_next = '0;
        if (cnt < LAST) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // The output is decoded from cnt_next, so clk == (cnt >= LOW) after every edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt <= '0;
            clk <= 1'b0;
        end else begin
            cnt <= cnt_next;
            clk <= (cnt_next >= LOW_C);
        end
    end

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: several instances with different DIV values,
// each driven through hand-computed vector tables and multi-cycle sequences.
module tb_clk_div;

    typedef struct {
        logic rst;
        logic exp_clk;
        int   exp_cnt;
    } vec_t;

    logic       clk_in = 1'b0;
    logic [4:0] rst_v  = 5'b11111;
    logic [4:0] clk_v;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_in = ~clk_in;

    // Index 0:DIV=5  1:DIV=4  2:DIV=2  3:DIV=7  4:DIV=3
    clk_div #(.DIV(5)) u_div5 (.clk_in(clk_in), .reset(rst_v[0]), .clk(clk_v[0]));
    clk_div #(.DIV(4)) u_div4 (.clk_in(clk_in), .reset(rst_v[1]), .clk(clk_v[1]));
    clk_div #(.DIV(2)) u_div2 (.clk_in(clk_in), .reset(rst_v[2]), .clk(clk_v[2]));
    clk_div #(.DIV(7)) u_div7 (.clk_in(clk_in), .reset(rst_v[3]), .clk(clk_v[3]));
    clk_div #(.DIV(3)) u_div3 (.clk_in(clk_in), .reset(rst_v[4]), .clk(clk_v[4]));

    function automatic logic [15:0] get_cnt(input int idx);
        logic [15:0] v;
        case (idx)
            0:       v = 16'(u_div5.cnt);
            1:       v = 16'(u_div4.cnt);
            2:       v = 16'(u_div2.cnt);
            3:       v = 16'(u_div7.cnt);
            default: v = 16'(u_div3.cnt);
        endcase
        return v;
    endfunction

    function automatic vec_t mk(input logic r, input logic c, input int n);
        vec_t v;
        v.rst     = r;
        v.exp_clk = c;
        v.exp_cnt = n;
        return v;
    endfunction

    task automatic check(input int idx, input logic ec, input int en, input string nm);
        logic        c;
        logic [15:0] n;
        c = clk_v[idx];
        n = get_cnt(idx);
        vectors++;
        if (c !== ec || n !== 16'(en)) begin
            errors++;
            $display("FAIL %s: got clk=%b cnt=%0d, expected clk=%b cnt=%0d", nm, c, n, ec, en);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic step(input int idx, input logic r, input logic ec, input int en, input string nm);
        rst_v[idx] = r;
        @(posedge clk_in);
        #1;
        check(idx, ec, en, nm);
    endtask

    vec_t t5[13];
    vec_t t4[10];
    vec_t t2[8];

    initial begin
        int   k;
        logic prev_c;
        int   run;
        bit   first_run;
        logic [15:0] n7;

        // DIV=5: 3 reset edges, then low 1,2 / high 3,4 / low 5,6,7 / high 8,9 / low 10
        for (int i = 0; i < 3; i++) t5[i] = mk(1'b1, 1'b0, 0);
        t5[3]  = mk(1'b0, 1'b0, 1);
        t5[4]  = mk(1'b0, 1'b0, 2);
        t5[5]  = mk(1'b0, 1'b1, 3);
        t5[6]  = mk(1'b0, 1'b1, 4);
        t5[7]  = mk(1'b0, 1'b0, 0);
        t5[8]  = mk(1'b0, 1'b0, 1);
        t5[9]  = mk(1'b0, 1'b0, 2);
        t5[10] = mk(1'b0, 1'b1, 3);
        t5[11] = mk(1'b0, 1'b1, 4);
        t5[12] = mk(1'b0, 1'b0, 0);

        // DIV=4: first rise on the 2nd edge after release
        for (int i = 0; i < 2; i++) t4[i] = mk(1'b1, 1'b0, 0);
        t4[2] = mk(1'b0, 1'b0, 1);
        t4[3] = mk(1'b0, 1'b1, 2);
        t4[4] = mk(1'b0, 1'b1, 3);
        t4[5] = mk(1'b0, 1'b0, 0);
        t4[6] = mk(1'b0, 1'b0, 1);
        t4[7] = mk(1'b0, 1'b1, 2);
        t4[8] = mk(1'b0, 1'b1, 3);
        t4[9] = mk(1'b0, 1'b0, 0);

        // DIV=2: toggles every edge, rising on the first
        for (int i = 0; i < 2; i++) t2[i] = mk(1'b1, 1'b0, 0);
        t2[2] = mk(1'b0, 1'b1, 1);
        t2[3] = mk(1'b0, 1'b0, 0);
        t2[4] = mk(1'b0, 1'b1, 1);
        t2[5] = mk(1'b0, 1'b0, 0);
        t2[6] = mk(1'b0, 1'b1, 1);
        t2[7] = mk(1'b0, 1'b0, 0);

        // DIV=5 startup, then 100 periods from the closed form
        for (int i = 0; i < 13; i++)
            step(0, t5[i].rst, t5[i].exp_clk, t5[i].exp_cnt, $sformatf("div5_start[%0d]", i));
        k = 10;
        for (int i = 0; i < 500; i++) begin
            k++;
            step(0, 1'b0, ((k % 5) >= 3), k % 5, $sformatf("div5_run[k=%0d]", k));
        end

        // DIV=5 reset pulse while clk is high (cnt=4), then the same restart phase
        for (int j = 0; j < 5 && (k % 5) != 4; j++) begin
            k++;
            step(0, 1'b0, ((k % 5) >= 3), k % 5, "div5_seek");
        end
        check(0, 1'b1, 4, "div5_high_before_reset");
        step(0, 1'b1, 1'b0, 0, "div5_midreset");
        for (int i = 3; i < 13; i++)
            step(0, t5[i].rst, t5[i].exp_clk, t5[i].exp_cnt, $sformatf("div5_restart[%0d]", i));

        for (int i = 0; i < 10; i++)
            step(1, t4[i].rst, t4[i].exp_clk, t4[i].exp_cnt, $sformatf("div4[%0d]", i));
        for (int i = 0; i < 8; i++)
            step(2, t2[i].rst, t2[i].exp_clk, t2[i].exp_cnt, $sformatf("div2[%0d]", i));

        // DIV=7 soak: pulse widths 3 high / 4 low, cnt bounded, no X
        step(3, 1'b1, 1'b0, 0, "div7_reset");
        prev_c    = 1'b0;
        run       = 1;
        first_run = 1'b1;
        for (int i = 1; i <= 2000; i++) begin
            step(3, 1'b0, ((i % 7) >= 4), i % 7, $sformatf("div7[%0d]", i));
            n7 = get_cnt(3);
            check_int("div7_cnt_bound", int'(n7 <= 16'd6 && !$isunknown(n7)), 1);
            check_int("div7_clk_known", int'(!$isunknown(clk_v[3])), 1);
            if (clk_v[3] === prev_c) begin
                run++;
            end else begin
                if (!first_run)
                    check_int(prev_c ? "div7_high_width" : "div7_low_width", run, prev_c ? 3 : 4);
                first_run = 1'b0;
                prev_c    = clk_v[3];
                run       = 1;
            end
        end

        // DIV=3 has had reset held since time zero
        for (int i = 0; i < 50; i++)
            step(4, 1'b1, 1'b0, 0, $sformatf("div3_held[%0d]", i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
